nf_rr_input_arbiter: RTL and testbench
======================================

// Module: nf_rr_input_arbiter
// PURPOSE
//  Parametrised N-input, packet-granular round-robin arbiter for the user data path.
//  Each input has its own FIFO; whole packets, module headers included, are merged onto one output stream.
//  Sits between the rx input queues and the output port lookup / output queues.
//  Replaces the fixed 8-port arbiter with packed, width-generic buses.
// PARAMETERS
//  DATA_WIDTH       64             data word width, bits
//  CTRL_WIDTH       DATA_WIDTH/8   ctrl word width, bits
//  NUM_INPUTS       8              number of input ports, >=2
//  FIFO_DEPTH_BITS  3              per-input FIFO depth = 2**FIFO_DEPTH_BITS words, >=2
// PORTS
//  clk       in   1                      clock
//  reset     in   1                      synchronous reset, active high
//  in_data   in   NUM_INPUTS*DATA_WIDTH  input data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_ctrl   in   NUM_INPUTS*CTRL_WIDTH  input ctrl, port i at [i*CTRL_WIDTH +: CTRL_WIDTH]
//  in_wr     in   NUM_INPUTS             per-port write strobe
//  in_rdy    out  NUM_INPUTS             per-port ready
//  out_data  out  DATA_WIDTH             merged data
//  out_ctrl  out  CTRL_WIDTH             merged ctrl
//  out_wr    out  1                      output write strobe
//  out_rdy   in   1                      downstream ready
//  ovf       out  NUM_INPUTS             sticky: word written to a full FIFO (dropped)
// BEHAVIOUR
//  Interface: one clock, clk. reset is synchronous, active high.
//  Reset values: in_rdy=all 1, out_wr=0, out_data=0, out_ctrl=0, ovf=0.
//  Reset also empties all FIFOs, sets state IDLE and sets grant pointer = NUM_INPUTS-1, so input 0 is first.
//  Reset mid-packet discards the partial packet. No output word follows the reset cycle.
//  Input side:
//   - in_rdy[i] = FIFO i fill < DEPTH-1, combinational from the registered fill count.
//   - This leaves one slack word for writers that sample in_rdy one cycle late.
//   - in_wr[i] when FIFO i is full: word dropped, ovf[i] set. Only reset clears ovf.
//  Packet framing, per word:
//   - ctrl!=0 before any ctrl==0 word is a module header.
//   - The first ctrl==0 word starts the payload.
//   - The next ctrl!=0 word is EOP.
//  FSM states:
//   - IDLE: scan from grant+1 modulo NUM_INPUTS for the first non-empty FIFO. On a hit, grant<=that index, go to HDR.
//   - HDR: pop while ctrl!=0. On the first ctrl==0 pop, go to PAYLOAD.
//   - PAYLOAD: pop. A popped word with ctrl!=0 is EOP: go to IDLE.
//   - IDLE costs exactly one bubble cycle between packets.
//  Pop rule: pop from FIFO[grant] in a cycle iff state!=IDLE, out_rdy=1 and FIFO[grant] is not empty.
//  An empty granted FIFO mid-packet stalls in the current state. The grant does not move until EOP.
//  Output timing:
//   - out_data/out_ctrl/out_wr are registered, one cycle after the pop.
//   - out_wr=1 only in the cycle after a pop.
//   - Downstream accepts one word after deasserting out_rdy.
//  Simultaneous write and pop on the same FIFO: fill is unchanged. The FIFO may be full.
//  Pointers wrap modulo DEPTH.
//  Fairness: with all inputs backlogged, packets are served 0,1,..,N-1,0,... One packet per grant.
// CONFIGURATION
//  NF_ARB_PKT_CNT_EN defined:
//   - Extra output pkt_cnt, NUM_INPUTS*32 bits.
//   - pkt_cnt[i] increments at every EOP popped from input i, wraps at 2**32, reset to 0.
//  NF_ARB_PKT_CNT_EN undefined: the pkt_cnt port and its counters do not exist. All other behaviour is identical.
// STRUCTURE
//  Shared include nf_arb_defines.v holds:
//   - FSM state encodings ARB_IDLE=2'd0, ARB_HDR=2'd1, ARB_PAYLOAD=2'd2.
//   - The log2 function.
//  Sub-module nf_arb_in_fifo: synchronous, first-word-fall-through, DATA_WIDTH+CTRL_WIDTH wide. Ports:
//   - wr, rd, din, dout
//   - empty, full, nearly_full (fill>=DEPTH-1)
//  The top instantiates it NUM_INPUTS times with a generate loop.
// TESTING
//  1. Single pkt on input 3, words: hdr ctrl=FF; payload 0,0; last ctrl=01. out_rdy=1 -> 4 words on out, same order. First out_wr 2 cycles after the first in_wr.
//  2. Inputs 0,1,2 each backlogged with 2 pkts. Output packet order is 0,1,2,0,1,2. Exactly 1 idle cycle between packets. No interleaving.
//  3. Hold out_rdy=0 for 5 cycles mid-packet -> no pops. At most 1 out_wr after the out_rdy fall. Stream resumes intact.
//  4. DEPTH=8, out_rdy=0, write 9 words to input 5:
//     - in_rdy[5] drops at fill=7.
//     - 9th word dropped and ovf[5]=1.
//     - The other ovf bits stay 0.
//  5. Assert reset for 1 cycle mid-packet on input 2:
//     - Next cycle out_wr=0, all in_rdy=1.
//     - A new pkt on input 2 is then delivered complete.
//  6. With NF_ARB_PKT_CNT_EN: send 3 pkts on input 0 and 1 pkt on input 7 -> pkt_cnt[0]=3, pkt_cnt[7]=1, all others 0.

Source files
------------

// File: rtl/nf_rr_input_arbiter_pkg.sv
// Shared types and helpers for the round-robin input arbiter.
//   arb_state_e : arbiter FSM states (IDLE / HDR / PAYLOAD)
//   log2        : ceiling log2, minimum result 1 (for index widths)
package nf_rr_input_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_HDR     = 2'd1,
    ARB_PAYLOAD = 2'd2
  } arb_state_e;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/nf_arb_in_fifo.sv
// Per-input synchronous first-word-fall-through FIFO.
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   wr, din      : write strobe and word; ignored when full unless a read
//                  happens in the same cycle
//   rd, dout     : read strobe (ignored when empty); dout shows the head word
//   empty, full  : fill == 0, fill == DEPTH
//   nearly_full  : fill >= DEPTH-1
module nf_arb_in_fifo #(
  parameter int unsigned WIDTH      = 72,
  parameter int unsigned DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             nearly_full
);
  import nf_rr_input_arbiter_pkg::*;

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] NEAR_CNT = (DEPTH_BITS+1)'(DEPTH - 1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                  wr_en, rd_en;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == FULL_CNT);
  assign nearly_full = (cnt_q >= NEAR_CNT);
  assign dout        = mem_q[rd_ptr_q];

  always_comb begin
    rd_en    = rd && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    wr_en    = wr && (!full || rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !rd_en) cnt_d = cnt_q + 1'b1;
    if (rd_en && !wr_en) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/nf_rr_input_arbiter.sv
// N-input packet-granular round-robin arbiter merging per-input FIFOs onto
// one registered output stream.
//   clk, reset          : clock, synchronous active-high reset
//   in_data/in_ctrl     : packed per-port input words
//   in_wr / in_rdy      : per-port write strobe / ready (fill < DEPTH-1)
//   out_data/out_ctrl   : merged registered output word
//   out_wr / out_rdy    : output strobe / downstream ready
//   ovf                 : sticky per-port overflow (word dropped on full FIFO)
//   pkt_cnt             : per-port 32-bit EOP counters, only when the macro
//                         NF_ARB_PKT_CNT_EN is defined
module nf_rr_input_arbiter #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned NUM_INPUTS      = 8,
  parameter int unsigned FIFO_DEPTH_BITS = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_INPUTS-1:0]            in_wr,
  output logic [NUM_INPUTS-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
`ifdef NF_ARB_PKT_CNT_EN
  output logic [NUM_INPUTS*32-1:0]         pkt_cnt,
`endif
  output logic [NUM_INPUTS-1:0]            ovf
);
  import nf_rr_input_arbiter_pkg::*;

  localparam int unsigned FW = DATA_WIDTH + CTRL_WIDTH;
  localparam int unsigned GW = log2(NUM_INPUTS);

  arb_state_e            state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [NUM_INPUTS-1:0] ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic                  out_wr_q, out_wr_d;

  logic [NUM_INPUTS-1:0] fifo_empty, fifo_full, fifo_nfull, fifo_rd;
  logic [FW-1:0]         fifo_dout [NUM_INPUTS];
  logic [FW-1:0]         head;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  pop;
  logic                  found;
  int unsigned           idx;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_fifo
    nf_arb_in_fifo #(
      .WIDTH      (FW),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .wr          (in_wr[i]),
      .rd          (fifo_rd[i]),
      .din         ({in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]}),
      .dout        (fifo_dout[i]),
      .empty       (fifo_empty[i]),
      .full        (fifo_full[i]),
      .nearly_full (fifo_nfull[i])
    );
  end

  assign in_rdy   = ~fifo_nfull;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign out_wr   = out_wr_q;
  assign ovf      = ovf_q;

  always_comb begin
    head      = fifo_dout[grant_q];
    head_ctrl = head[FW-1 -: CTRL_WIDTH];
    pop       = (state_q != ARB_IDLE) && out_rdy && !fifo_empty[grant_q];
    fifo_rd          = '0;
    fifo_rd[grant_q] = pop;
    state_d   = state_q;
    grant_d   = grant_q;
    found     = 1'b0;
    idx       = 0;
    unique case (state_q)
      ARB_IDLE: begin
        // First non-empty input searching upward from the one after the last grant.
        for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
          idx = (32'(grant_q) + k) % NUM_INPUTS;
          if (!found && !fifo_empty[idx]) begin
            found   = 1'b1;
            grant_d = GW'(idx);
            state_d = ARB_HDR;
          end
        end
      end
      ARB_HDR:     if (pop && head_ctrl == '0) state_d = ARB_PAYLOAD;
      ARB_PAYLOAD: if (pop && head_ctrl != '0) state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
    ovf_d      = ovf_q | (in_wr & fifo_full & ~fifo_rd);
    out_wr_d   = pop;
    out_data_d = pop ? head[DATA_WIDTH-1:0] : out_data_q;
    out_ctrl_d = pop ? head_ctrl : out_ctrl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= GW'(NUM_INPUTS - 1);
      ovf_q      <= '0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      out_wr_q   <= out_wr_d;
    end
  end

`ifdef NF_ARB_PKT_CNT_EN
  logic [NUM_INPUTS-1:0][31:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (state_q == ARB_PAYLOAD && pop && head_ctrl != '0)
      pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) pkt_cnt_q <= '0;
    else       pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_nf_rr_input_arbiter.sv
module tb_nf_rr_input_arbiter;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] in_data;
  logic [N*CW-1:0] in_ctrl;
  logic [N-1:0]    in_wr;
  logic [N-1:0]    in_rdy;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic            out_wr;
  logic            out_rdy;
  logic [N-1:0]    ovf;
`ifdef NF_ARB_PKT_CNT_EN
  logic [N*32-1:0] pkt_cnt;
`endif

  nf_rr_input_arbiter #(
    .DATA_WIDTH      (DW),
    .CTRL_WIDTH      (CW),
    .NUM_INPUTS      (N),
    .FIFO_DEPTH_BITS (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .in_wr    (in_wr),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .out_wr   (out_wr),
    .out_rdy  (out_rdy),
`ifdef NF_ARB_PKT_CNT_EN
    .pkt_cnt  (pkt_cnt),
`endif
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [CW+DW-1:0] exp_q[$];
  int out_cyc[$];
  int out_cnt = 0;
  int last_wr_cyc = 0;

  // Scoreboard monitor: every output word must match the head of the queue.
  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      logic [CW+DW-1:0] e;
      out_cnt++;
      out_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out: got ctrl=%h data=%h, required no output", out_ctrl, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_ctrl, out_data} !== e) begin
          failures++;
          $display("FAIL out_word: got ctrl=%h data=%h, required ctrl=%h data=%h",
                   out_ctrl, out_data, e[CW+DW-1 -: CW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int p, input int k, input int w);
    return {32'hA5A5_0000, 8'(p), 8'(k), 16'(w)};
  endfunction

  // Framing: first word header, last word EOP, middle words payload.
  function automatic logic [CW-1:0] mk_ctrl(input int w, input int n);
    if (w == 0)     return 8'hFF;
    if (w == n - 1) return 8'h01;
    return 8'h00;
  endfunction

  task automatic send_word(input int p, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_data[p*DW +: DW] = d;
    in_ctrl[p*CW +: CW] = c;
    in_wr[p] = 1'b1;
    @(posedge clk);
    #1;
    last_wr_cyc = cyc;
    in_wr[p] = 1'b0;
  endtask

  task automatic push_pkt(input int p, input int k, input int n);
    for (int w = 0; w < n; w++) exp_q.push_back({mk_ctrl(w, n), mk_data(p, k, w)});
  endtask

  task automatic load_pkt(input int p, input int k, input int n, input bit push);
    if (push) push_pkt(p, k, n);
    for (int w = 0; w < n; w++) send_word(p, mk_data(p, k, w), mk_ctrl(w, n));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_pending", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int first_wr;
    int snap;
    reset = 1'b1; out_rdy = 1'b1; in_wr = '0; in_data = '0; in_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'hFF);
    chk("rst_out_wr", 64'(out_wr), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", 64'(out_ctrl), 0);
    chk("rst_ovf", 64'(ovf), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single packet on input 3, latency from first write to first out_wr.
    out_cyc.delete();
    push_pkt(3, 0, 4);
    send_word(3, mk_data(3, 0, 0), mk_ctrl(0, 4));
    first_wr = last_wr_cyc;
    for (int w = 1; w < 4; w++) send_word(3, mk_data(3, 0, w), mk_ctrl(w, 4));
    wait_drain();
    chk("t1_nwords", 64'(out_cyc.size()), 4);
    if (out_cyc.size() > 0) chk("t1_latency", 64'(out_cyc[0] - first_wr), 2);

    // 2: inputs 0,1,2 backlogged with 2 packets each.
    out_rdy = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 2; k++) load_pkt(p, k, 3, 1'b0);
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 3; p++) push_pkt(p, k, 3);
    out_cyc.delete();
    out_rdy = 1'b1;
    wait_drain();
    chk("t2_nwords", 64'(out_cyc.size()), 18);
    for (int j = 1; j < out_cyc.size(); j++)
      chk($sformatf("t2_gap%0d", j), 64'(out_cyc[j] - out_cyc[j-1]), (j % 3 == 0) ? 2 : 1);

    // 3: out_rdy low for 5 cycles in the middle of a packet on input 1.
    load_pkt(1, 0, 6, 1'b1);
    out_rdy = 1'b0;
    snap = out_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_stall_le1", 64'((out_cnt - snap) <= 1), 1);
    chk("t3_pending", 64'(exp_q.size()), 2);
    out_rdy = 1'b1;
    wait_drain();

    // 4: overflow on input 5 with downstream blocked.
    do_reset();
    out_rdy = 1'b0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t4_in_rdy_fill%0d", k), 64'(in_rdy[5]), (k < 7) ? 1 : 0);
      if (k == 8) chk("t4_ovf_before", 64'(ovf), 0);
      send_word(5, mk_data(5, 0, k), 8'hFF);
    end
    chk("t4_ovf_after", 64'(ovf), 64'h20);
    do_reset();
    chk("t4_ovf_cleared", 64'(ovf), 0);
    out_rdy = 1'b1;

    // 5: reset in the middle of a packet on input 2.
    exp_q.push_back({8'hFF, mk_data(2, 0, 0)});
    send_word(2, mk_data(2, 0, 0), 8'hFF);
    send_word(2, mk_data(2, 0, 1), 8'h00);
    send_word(2, mk_data(2, 0, 2), 8'h00);
    do_reset();
    chk("t5_out_wr", 64'(out_wr), 0);
    chk("t5_in_rdy", 64'(in_rdy), 64'hFF);
    chk("t5_head_seen", 64'(exp_q.size()), 0);
    load_pkt(2, 1, 4, 1'b1);
    wait_drain();

`ifdef NF_ARB_PKT_CNT_EN
    // 6: per-input EOP counters.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      load_pkt(0, k, 3, 1'b1);
      wait_drain();
    end
    load_pkt(7, 0, 3, 1'b1);
    wait_drain();
    for (int i = 0; i < N; i++)
      chk($sformatf("t6_pkt_cnt%0d", i), 64'(pkt_cnt[i*32 +: 32]), (i == 0) ? 3 : (i == 7) ? 1 : 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
